// File: rtl/inertial_integrator_cal.sv
// Pitch integrator for the balance loop: offset-compensated gyro integration with accel fusion
// nudging, runtime offset calibration by averaging, two-stage pipeline and saturating accumulator.
module inertial_integrator_cal #(
    parameter int unsigned  W           = 16,
    parameter int unsigned  FRAC        = 11,
    parameter int unsigned  FUSE_STEP   = 1024,
    parameter int           FUDGE       = 327,
    parameter int unsigned  FUDGE_SHIFT = 13,
    parameter int unsigned  CAL_LOG2    = 8,
    parameter logic [W-1:0] RT_OFF_DFLT = 16'h03C2,
    parameter logic [W-1:0] AZ_OFF_DFLT = 16'hFE80
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         vld,
    input  logic [W-1:0] ptch_rt,
    input  logic [W-1:0] AZ,
    input  logic         cal_start,
    output logic [W-1:0] ptch,
    output logic         ptch_vld,
    output logic         cal_busy,
    output logic         cal_done,
    output logic         sat
);

    localparam int unsigned INT_W = W + FRAC;
    localparam int unsigned SUM_W = W + CAL_LOG2;
    localparam int unsigned NXT_W = INT_W + 2;

    localparam logic signed [NXT_W-1:0] MaxV  = $signed({3'b000, {(INT_W-1){1'b1}}});
    localparam logic signed [NXT_W-1:0] MinV  = $signed({3'b111, {(INT_W-1){1'b0}}});
    localparam logic signed [NXT_W-1:0] StepP = NXT_W'(FUSE_STEP);
    localparam logic signed [NXT_W-1:0] StepN = -StepP;
    localparam logic signed [2*W-1:0]   FudgeX = (2*W)'(FUDGE);

    typedef enum logic {StRun = 1'b0, StCal = 1'b1} state_e;

    state_e              state_q, state_d;
    logic [INT_W-1:0]    ptch_int_q, ptch_int_d;
    logic [W-1:0]        rt_off_q, rt_off_d, az_off_q, az_off_d;
    logic [SUM_W-1:0]    sum_rt_q, sum_rt_d, sum_az_q, sum_az_d;
    logic [CAL_LOG2-1:0] cnt_q, cnt_d;
    logic [W-1:0]        rt_comp_q, rt_comp_d, az_comp_q, az_comp_d;
    logic                v1_q, v1_d;
    logic                ptch_vld_q, ptch_vld_d;
    logic                cal_done_q, cal_done_d;
    logic                sat_q, sat_d;

    logic signed [2*W-1:0]  prod;
    logic signed [W-1:0]    acc_p, ptch_s;
    logic signed [NXT_W-1:0] step, nxt;
    logic                   clamp_hi, clamp_lo;
    logic [SUM_W-1:0]       sum_rt_nxt, sum_az_nxt;

    // Second pipeline stage: fusion step and clamped integrator update.
    always_comb begin
        prod     = $signed({{W{az_comp_q[W-1]}}, az_comp_q}) * FudgeX;
        acc_p    = W'(prod >>> FUDGE_SHIFT);
        ptch_s   = $signed(ptch_int_q[INT_W-1:FRAC]);
        step     = (acc_p > ptch_s) ? StepP : StepN;
        nxt      = $signed({{2{ptch_int_q[INT_W-1]}}, ptch_int_q})
                 - $signed({{(NXT_W-W){rt_comp_q[W-1]}}, rt_comp_q})
                 + step;
        clamp_hi = nxt > MaxV;
        clamp_lo = nxt < MinV;
        sum_rt_nxt = sum_rt_q + {{CAL_LOG2{ptch_rt[W-1]}}, ptch_rt};
        sum_az_nxt = sum_az_q + {{CAL_LOG2{AZ[W-1]}}, AZ};
    end

    always_comb begin
        state_d    = state_q;
        ptch_int_d = ptch_int_q;
        rt_off_d   = rt_off_q;
        az_off_d   = az_off_q;
        sum_rt_d   = sum_rt_q;
        sum_az_d   = sum_az_q;
        cnt_d      = cnt_q;
        rt_comp_d  = rt_comp_q;
        az_comp_d  = az_comp_q;
        v1_d       = 1'b0;
        ptch_vld_d = 1'b0;
        cal_done_d = 1'b0;
        sat_d      = sat_q;
        unique case (state_q)
            StRun: begin
                if (cal_start) begin
                    // Any sample in flight is discarded on entry to calibration.
                    state_d  = StCal;
                    sum_rt_d = '0;
                    sum_az_d = '0;
                    cnt_d    = '0;
                    sat_d    = 1'b0;
                end else begin
                    if (vld) begin
                        rt_comp_d = ptch_rt - rt_off_q;
                        az_comp_d = AZ - az_off_q;
                    end
                    v1_d = vld;
                    if (v1_q) begin
                        ptch_vld_d = 1'b1;
                        if (clamp_hi) begin
                            ptch_int_d = MaxV[INT_W-1:0];
                            sat_d      = 1'b1;
                        end else if (clamp_lo) begin
                            ptch_int_d = MinV[INT_W-1:0];
                            sat_d      = 1'b1;
                        end else begin
                            ptch_int_d = nxt[INT_W-1:0];
                        end
                    end
                end
            end
            StCal: begin
                if (vld) begin
                    sum_rt_d = sum_rt_nxt;
                    sum_az_d = sum_az_nxt;
                    cnt_d    = cnt_q + CAL_LOG2'(1);
                    if (cnt_q == '1) begin
                        state_d    = StRun;
                        rt_off_d   = sum_rt_nxt[SUM_W-1:CAL_LOG2];
                        az_off_d   = sum_az_nxt[SUM_W-1:CAL_LOG2];
                        ptch_int_d = '0;
                        cal_done_d = 1'b1;
                    end
                end
            end
            default: state_d = StRun;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StRun;
            ptch_int_q <= '0;
            rt_off_q   <= RT_OFF_DFLT;
            az_off_q   <= AZ_OFF_DFLT;
            sum_rt_q   <= '0;
            sum_az_q   <= '0;
            cnt_q      <= '0;
            rt_comp_q  <= '0;
            az_comp_q  <= '0;
            v1_q       <= 1'b0;
            ptch_vld_q <= 1'b0;
            cal_done_q <= 1'b0;
            sat_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptch_int_q <= ptch_int_d;
            rt_off_q   <= rt_off_d;
            az_off_q   <= az_off_d;
            sum_rt_q   <= sum_rt_d;
            sum_az_q   <= sum_az_d;
            cnt_q      <= cnt_d;
            rt_comp_q  <= rt_comp_d;
            az_comp_q  <= az_comp_d;
            v1_q       <= v1_d;
            ptch_vld_q <= ptch_vld_d;
            cal_done_q <= cal_done_d;
            sat_q      <= sat_d;
        end
    end

    assign ptch     = ptch_int_q[INT_W-1:FRAC];
    assign ptch_vld = ptch_vld_q;
    assign cal_busy = (state_q == StCal);
    assign cal_done = cal_done_q;
    assign sat      = sat_q;

endmodule

// File: tb/tb_inertial_integrator_cal.sv
// Bench for inertial_integrator_cal: hand-computed vector table, directed corner sequences and
// randomized stimulus against an arithmetic reference model.
module tb_inertial_integrator_cal;

    logic        clk = 1'b0;
    logic        rst, vld, cal_start;
    logic [15:0] ptch_rt, az, ptch;
    logic        ptch_vld, cal_busy, cal_done, sat;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    inertial_integrator_cal dut (
        .clk       (clk),
        .rst       (rst),
        .vld       (vld),
        .ptch_rt   (ptch_rt),
        .AZ        (az),
        .cal_start (cal_start),
        .ptch      (ptch),
        .ptch_vld  (ptch_vld),
        .cal_busy  (cal_busy),
        .cal_done  (cal_done),
        .sat       (sat)
    );

    // Reference model state, plain integers.
    bit     m_cal, m_pend, m_sat, m_vld, m_done;
    longint m_acc;
    int     m_rt_off, m_az_off, m_sum_rt, m_sum_az, m_cnt, m_rt_c, m_az_c;
    localparam longint AccMax = 64'sd67108863;
    localparam longint AccMin = -64'sd67108864;

    function automatic int s16(input int x);
        logic [15:0] t;
        t = x[15:0];
        return int'($signed(t));
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input bit r, input bit v, input bit cs,
                              input logic [15:0] rt, input logic [15:0] a);
        int pitch, accp;
        longint n;
        m_vld  = 0;
        m_done = 0;
        if (r) begin
            m_cal = 0; m_pend = 0; m_sat = 0; m_acc = 0;
            m_rt_off = 16'h03C2; m_az_off = s16(16'hFE80);
            m_sum_rt = 0; m_sum_az = 0; m_cnt = 0;
        end else if (!m_cal) begin
            if (cs) begin
                m_cal = 1; m_sum_rt = 0; m_sum_az = 0; m_cnt = 0; m_sat = 0; m_pend = 0;
            end else begin
                if (m_pend) begin
                    pitch = int'(m_acc >>> 11);
                    accp  = s16((m_az_c * 327) >>> 13);
                    n = m_acc - m_rt_c + ((accp > pitch) ? 1024 : -1024);
                    if (n > AccMax) begin n = AccMax; m_sat = 1; end
                    if (n < AccMin) begin n = AccMin; m_sat = 1; end
                    m_acc = n;
                    m_vld = 1;
                end
                m_pend = v;
                if (v) begin
                    m_rt_c = s16(int'($signed(rt)) - m_rt_off);
                    m_az_c = s16(int'($signed(a)) - m_az_off);
                end
            end
        end else if (v) begin
            m_sum_rt += int'($signed(rt));
            m_sum_az += int'($signed(a));
            m_cnt++;
            if (m_cnt == 256) begin
                m_rt_off = s16(m_sum_rt >>> 8);
                m_az_off = s16(m_sum_az >>> 8);
                m_acc = 0; m_cal = 0; m_done = 1;
            end
        end
    endtask

    task automatic step(input bit r, input bit v, input bit cs,
                        input logic [15:0] rt, input logic [15:0] a);
        rst = r; vld = v; cal_start = cs; ptch_rt = rt; az = a;
        @(posedge clk);
        model_edge(r, v, cs, rt, a);
        @(negedge clk);
    endtask

    task automatic chk_model(input string tag);
        chk({tag, "_ptch"}, ptch, 16'(m_acc >>> 11));
        chk({tag, "_vld"},  {15'd0, ptch_vld}, {15'd0, m_vld});
        chk({tag, "_busy"}, {15'd0, cal_busy}, {15'd0, m_cal});
        chk({tag, "_done"}, {15'd0, cal_done}, {15'd0, m_done});
        chk({tag, "_sat"},  {15'd0, sat},      {15'd0, m_sat});
    endtask

    typedef struct {
        bit          r, v, cs;
        logic [15:0] rt, a, e_ptch;
        bit          e_vld, e_busy, e_done, e_sat;
    } vec_t;

    initial begin
        vec_t tbl[15];
        bit   early;
        tbl[0]  = '{1, 0, 0, 16'h03C2, 16'hFE80, 16'h0000, 0, 0, 0, 0};
        tbl[1]  = '{0, 1, 0, 16'h03C2, 16'hFE80, 16'h0000, 0, 0, 0, 0};
        tbl[2]  = '{0, 1, 0, 16'h03C2, 16'hFE80, 16'hFFFF, 1, 0, 0, 0};
        tbl[3]  = '{0, 1, 0, 16'h03C2, 16'hFE80, 16'h0000, 1, 0, 0, 0};
        tbl[4]  = '{0, 1, 0, 16'h03C2, 16'hFE80, 16'hFFFF, 1, 0, 0, 0};
        tbl[5]  = '{0, 0, 0, 16'h03C2, 16'hFE80, 16'h0000, 1, 0, 0, 0};
        tbl[6]  = '{0, 0, 0, 16'h03C2, 16'hFE80, 16'h0000, 0, 0, 0, 0};
        tbl[7]  = '{0, 1, 0, 16'h13C2, 16'hFE80, 16'h0000, 0, 0, 0, 0};
        tbl[8]  = '{0, 1, 0, 16'h13C2, 16'hFE80, 16'hFFFD, 1, 0, 0, 0};
        tbl[9]  = '{0, 1, 0, 16'h13C2, 16'hFE80, 16'hFFFC, 1, 0, 0, 0};
        tbl[10] = '{0, 1, 0, 16'h13C2, 16'hFE80, 16'hFFFA, 1, 0, 0, 0};
        tbl[11] = '{0, 0, 0, 16'h13C2, 16'hFE80, 16'hFFF9, 1, 0, 0, 0};
        tbl[12] = '{0, 0, 0, 16'h13C2, 16'hFE80, 16'hFFF9, 0, 0, 0, 0};
        tbl[13] = '{0, 0, 1, 16'h13C2, 16'hFE80, 16'hFFF9, 0, 1, 0, 0};
        tbl[14] = '{0, 1, 0, 16'h13C2, 16'hFE80, 16'hFFF9, 0, 1, 0, 0};

        for (int i = 0; i < 15; i++) begin
            step(tbl[i].r, tbl[i].v, tbl[i].cs, tbl[i].rt, tbl[i].a);
            chk($sformatf("tbl%0d_ptch", i), ptch, tbl[i].e_ptch);
            chk($sformatf("tbl%0d_vld", i),  {15'd0, ptch_vld}, {15'd0, tbl[i].e_vld});
            chk($sformatf("tbl%0d_busy", i), {15'd0, cal_busy}, {15'd0, tbl[i].e_busy});
            chk($sformatf("tbl%0d_done", i), {15'd0, cal_done}, {15'd0, tbl[i].e_done});
            chk($sformatf("tbl%0d_sat", i),  {15'd0, sat},      {15'd0, tbl[i].e_sat});
        end

        // 16 samples of rt_comp=4096 settle at ptch_int=-51200.
        step(1, 0, 0, 16'h0, 16'h0);
        for (int i = 0; i < 16; i++) step(0, 1, 0, 16'h13C2, 16'hFE80);
        step(0, 0, 0, 16'h13C2, 16'hFE80);
        chk("int16_ptch", ptch, 16'hFFE7);
        chk("int16_sat", {15'd0, sat}, 16'd0);

        // Positive saturation, sticky flag, cleared by cal_start.
        step(1, 0, 0, 16'h0, 16'h0);
        for (int i = 0; i < 2200; i++) step(0, 1, 0, 16'h83C2, 16'hFE80);
        chk("satur_ptch", ptch, 16'h7FFF);
        chk("satur_sat", {15'd0, sat}, 16'd1);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 16'h03C2, 16'hFE80);
        chk("satur_sticky", {15'd0, sat}, 16'd1);
        step(0, 0, 1, 16'h0400, 16'h0010);
        chk("calstart_sat_clr", {15'd0, sat}, 16'd0);
        chk("calstart_busy", {15'd0, cal_busy}, 16'd1);

        // Calibration to new offsets, then dither reproduced at the new operating point.
        early = 0;
        for (int i = 1; i <= 256; i++) begin
            step(0, 1, 0, 16'h0400, 16'h0010);
            if (i < 256 && (cal_done || !cal_busy)) early = 1;
        end
        chk("cal_early_exit", {15'd0, early}, 16'd0);
        chk("cal_done_pulse", {15'd0, cal_done}, 16'd1);
        chk("cal_busy_drop", {15'd0, cal_busy}, 16'd0);
        chk("cal_ptch_zero", ptch, 16'h0000);
        step(0, 1, 0, 16'h0400, 16'h0010);
        chk("cal_done_1cyc", {15'd0, cal_done}, 16'd0);
        step(0, 1, 0, 16'h0400, 16'h0010);
        chk("postcal_dither_a", ptch, 16'hFFFF);
        step(0, 1, 0, 16'h0400, 16'h0010);
        chk("postcal_dither_b", ptch, 16'h0000);

        // Reset in the middle of calibration restores defaults without cal_done.
        step(0, 0, 1, 16'h0400, 16'h0010);
        for (int i = 0; i < 100; i++) step(0, 1, 0, 16'h0400, 16'h0010);
        step(1, 0, 0, 16'h03C2, 16'hFE80);
        chk("rstcal_busy", {15'd0, cal_busy}, 16'd0);
        chk("rstcal_ptch", ptch, 16'h0000);
        step(0, 1, 0, 16'h03C2, 16'hFE80);
        chk("rstcal_done", {15'd0, cal_done}, 16'd0);
        step(0, 1, 0, 16'h03C2, 16'hFE80);
        chk("rstcal_dflt_dither", ptch, 16'hFFFF);

        // cal_start inside calibration is ignored.
        step(0, 0, 1, 16'h03C2, 16'hFE80);
        early = 0;
        for (int i = 1; i <= 256; i++) begin
            step(0, 1, (i == 51), 16'h03C2, 16'hFE80);
            if (i < 256 && cal_done) early = 1;
        end
        chk("recal_ignored_early", {15'd0, early}, 16'd0);
        chk("recal_ignored_done", {15'd0, cal_done}, 16'd1);

        // Randomized traffic against the reference model.
        step(1, 0, 0, 16'h0, 16'h0);
        chk_model("rand_rst");
        for (int i = 0; i < 3000; i++) begin
            logic [15:0] rt, a;
            rt = ($urandom_range(0, 7) == 0) ? 16'($urandom)
                                             : 16'(32'h03C2 + $urandom_range(0, 1023) - 512);
            a  = ($urandom_range(0, 7) == 0) ? 16'($urandom)
                                             : 16'(32'hFE80 + $urandom_range(0, 4095) - 2048);
            step(($urandom_range(0, 999) == 0), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 299) == 0), rt, a);
            chk_model("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
